// File: rtl/dafx_mix_sequencer.sv
// Sample-rate sequencer: on each host tick, streams every channel through one shared
// multiplier, accumulates the gained samples and emits one saturated mixed sample.
module dafx_mix_sequencer #(
    parameter int SYS_CLK_FREQUENCY_P = 125000000,
    parameter int F_SAMPLING_P        = 10000,
    parameter int NR_OF_CHANNELS_P    = 3,
    parameter int AUDIO_WIDTH_P       = 24,
    parameter int GAIN_WIDTH_P        = 24,
    parameter int Q_BITS_P            = 11
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic                                      cr_enable,
    input  logic [NR_OF_CHANNELS_P*GAIN_WIDTH_P-1:0]  cr_gain,
    input  logic [NR_OF_CHANNELS_P*AUDIO_WIDTH_P-1:0] ch_data,
    output logic                                      egr_mul_valid,
    input  logic                                      egr_mul_ready,
    output logic [AUDIO_WIDTH_P-1:0]                  egr_mul_sample,
    output logic [GAIN_WIDTH_P-1:0]                   egr_mul_gain,
    input  logic                                      ing_mul_valid,
    input  logic [AUDIO_WIDTH_P+GAIN_WIDTH_P-1:0]     ing_mul_product,
    output logic                                      mix_valid,
    output logic [AUDIO_WIDTH_P-1:0]                  mix_data,
    output logic                                      sampling_irq,
    output logic [15:0]                               sr_overrun_count
);

    localparam int N     = NR_OF_CHANNELS_P;
    localparam int AW    = AUDIO_WIDTH_P;
    localparam int GW    = GAIN_WIDTH_P;
    localparam int PW    = AW + GW;
    localparam int ACC_W = PW + $clog2(N) + 1;
    localparam int DIV_C = SYS_CLK_FREQUENCY_P / F_SAMPLING_P;
    localparam int CNT_W = $clog2(DIV_C);
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DIV_C - 1);
    localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(N - 1);
    localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-AW+1){1'b0}}, {(AW-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-AW+1){1'b1}}, {(AW-1){1'b0}}};

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_OUT
    } state_t;

    state_t                     r_state;
    state_t                     w_state_nxt;
    logic [CNT_W-1:0]           r_cnt;
    logic [N-1:0][AW-1:0]       r_data;
    logic [N-1:0][GW-1:0]       r_gain;
    logic [IDX_W-1:0]           r_idx;
    logic signed [ACC_W-1:0]    r_acc;
    logic [AW-1:0]              r_mix_data;
    logic [15:0]                r_overrun;

    logic                       w_tick;
    logic                       w_latch;
    logic                       w_acc_en;
    logic                       w_last;
    logic                       w_drop;
    logic signed [ACC_W-1:0]    w_prod_ext;
    logic signed [ACC_W-1:0]    w_acc_next;
    logic signed [ACC_W-1:0]    w_shift;
    logic [AW-1:0]              w_sat;

    // Gated by rst so no irq can leak out while reset is held.
    assign w_tick = cr_enable && !rst && (r_cnt == CNT_MAX);
    assign w_last = (r_idx == IDX_MAX);
    assign w_drop = w_tick && (r_state != ST_IDLE);

    always_ff @(posedge clk) begin
        if (rst || !cr_enable) begin
            r_cnt <= '0;
        end else if (r_cnt == CNT_MAX) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_latch     = 1'b0;
        w_acc_en    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_tick) begin
                    w_latch     = 1'b1;
                    w_state_nxt = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (egr_mul_ready) w_state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                if (ing_mul_valid) begin
                    w_acc_en    = 1'b1;
                    w_state_nxt = w_last ? ST_OUT : ST_ISSUE;
                end
            end
            ST_OUT: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Accumulate and rescale; arithmetic shift floors negative values.
    assign w_prod_ext = {{(ACC_W-PW){ing_mul_product[PW-1]}}, ing_mul_product};
    assign w_acc_next = r_acc + w_prod_ext;
    assign w_shift    = w_acc_next >>> Q_BITS_P;

    always_comb begin
        w_sat = w_shift[AW-1:0];
        if (w_shift > SAT_MAX) begin
            w_sat = SAT_MAX[AW-1:0];
        end else if (w_shift < SAT_MIN) begin
            w_sat = SAT_MIN[AW-1:0];
        end
    end

    // The mixed sample is registered on the last product so it is ready in OUT.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_data     <= '0;
            r_gain     <= '0;
            r_idx      <= '0;
            r_acc      <= '0;
            r_mix_data <= '0;
        end else if (w_latch) begin
            r_data <= ch_data;
            r_gain <= cr_gain;
            r_idx  <= '0;
            r_acc  <= '0;
        end else if (w_acc_en) begin
            r_acc <= w_acc_next;
            if (w_last) begin
                r_mix_data <= w_sat;
            end else begin
                r_idx <= r_idx + IDX_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_overrun <= '0;
        end else if (w_drop && (r_overrun != 16'hFFFF)) begin
            r_overrun <= r_overrun + 16'd1;
        end
    end

    assign egr_mul_valid    = (r_state == ST_ISSUE);
    assign egr_mul_sample   = r_data[r_idx];
    assign egr_mul_gain     = r_gain[r_idx];
    assign mix_valid        = (r_state == ST_OUT);
    assign mix_data         = r_mix_data;
    assign sampling_irq     = w_latch;
    assign sr_overrun_count = r_overrun;

endmodule

// File: tb/tb_dafx_mix_sequencer.sv
// Directed bench for dafx_mix_sequencer: vector table for the mix arithmetic plus
// hand sequences for overrun, mid-frame reset and enable drop.
module tb_dafx_mix_sequencer;

    localparam int N  = 3;
    localparam int AW = 24;
    localparam int GW = 24;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 cr_enable = 1'b0;
    logic [N*GW-1:0]      cr_gain = '0;
    logic [N*AW-1:0]      ch_data = '0;
    logic                 egr_mul_valid;
    logic                 egr_mul_ready = 1'b1;
    logic [AW-1:0]        egr_mul_sample;
    logic [GW-1:0]        egr_mul_gain;
    logic                 ing_mul_valid;
    logic [AW+GW-1:0]     ing_mul_product;
    logic                 mix_valid;
    logic [AW-1:0]        mix_data;
    logic                 sampling_irq;
    logic [15:0]          sr_overrun_count;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    dafx_mix_sequencer #(
        .SYS_CLK_FREQUENCY_P (100),
        .F_SAMPLING_P        (10),
        .NR_OF_CHANNELS_P    (N),
        .AUDIO_WIDTH_P       (AW),
        .GAIN_WIDTH_P        (GW),
        .Q_BITS_P            (11)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .cr_enable        (cr_enable),
        .cr_gain          (cr_gain),
        .ch_data          (ch_data),
        .egr_mul_valid    (egr_mul_valid),
        .egr_mul_ready    (egr_mul_ready),
        .egr_mul_sample   (egr_mul_sample),
        .egr_mul_gain     (egr_mul_gain),
        .ing_mul_valid    (ing_mul_valid),
        .ing_mul_product  (ing_mul_product),
        .mix_valid        (mix_valid),
        .mix_data         (mix_data),
        .sampling_irq     (sampling_irq),
        .sr_overrun_count (sr_overrun_count)
    );

    // Multiplier model: product appears the cycle after the operand handshake.
    logic signed [AW+GW-1:0] mul_p;
    assign mul_p = (AW+GW)'($signed(egr_mul_sample)) * (AW+GW)'($signed(egr_mul_gain));

    always @(posedge clk) begin
        if (rst) begin
            ing_mul_valid   <= 1'b0;
            ing_mul_product <= '0;
        end else begin
            ing_mul_valid   <= egr_mul_valid && egr_mul_ready;
            ing_mul_product <= mul_p;
        end
    end

    typedef struct {
        string           nm;
        logic [N*GW-1:0] g;
        logic [N*AW-1:0] s;
        logic [AW-1:0]   exp;
    } vec_t;

    function automatic vec_t mk(input string nm, input logic [N*GW-1:0] g,
                                input logic [N*AW-1:0] s, input logic [AW-1:0] exp);
        vec_t v;
        v.nm  = nm;
        v.g   = g;
        v.s   = s;
        v.exp = exp;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // which: 0 = sampling_irq, 1 = mix_valid. n = negedges waited, -1 on timeout.
    task automatic wait_pulse(input int which, input int bound, input string nm, output int n);
        for (int k = 1; k <= bound; k++) begin
            @(negedge clk);
            if ((which == 0 && sampling_irq) || (which == 1 && mix_valid)) begin
                n = k;
                return;
            end
        end
        n = -1;
        n_cmp++;
        n_err++;
        $display("FAIL %s: no pulse within %0d cycles, want one", nm, bound);
    endtask

    vec_t vt[7];

    initial begin
        int n;
        int c_irq;
        int c_mix;
        int k_irq;

        // channel order in each concatenation is {ch2, ch1, ch0}
        vt[0] = mk("unity",    {24'd2048, 24'd2048, 24'd2048}, {24'd300, 24'd200, 24'd100}, 24'd600);
        vt[1] = mk("pos_sat",  {24'd2048, 24'd2048, 24'd2048}, {24'h7FFFFF, 24'h7FFFFF, 24'h7FFFFF}, 24'h7FFFFF);
        vt[2] = mk("neg_sat",  {24'd2048, 24'd2048, 24'd2048}, {24'h800000, 24'h800000, 24'h800000}, 24'h800000);
        vt[3] = mk("half_neg", {24'd0, 24'd0, 24'd1024}, {24'd77, 24'd55, 24'hFFFC18}, 24'hFFFE0C);
        vt[4] = mk("floor",    {24'd0, 24'd0, 24'd1024}, {24'd0, 24'd0, 24'hFFFFFD}, 24'hFFFFFE);
        vt[5] = mk("mixed",    {24'd1024, 24'hFFF800, 24'd4096}, {24'hFFFFF8, 24'd500, 24'd1000}, 24'h0005D8);
        vt[6] = mk("tiny_neg", {24'd0, 24'd0, 24'd1}, {24'd0, 24'd0, 24'hFFFFFB}, 24'hFFFFFF);

        repeat (3) @(negedge clk);
        chk("rst_egr_valid", egr_mul_valid, 0);
        chk("rst_mix_valid", mix_valid, 0);
        chk("rst_mix_data", mix_data, 0);
        chk("rst_irq", sampling_irq, 0);
        chk("rst_overrun", sr_overrun_count, 0);
        chk("rst_sample", egr_mul_sample, 0);
        chk("rst_gain", egr_mul_gain, 0);
        rst = 1'b0;
        cr_enable = 1'b1;

        for (int i = 0; i < 7; i++) begin
            cr_gain = vt[i].g;
            ch_data = vt[i].s;
            wait_pulse(0, 25, {vt[i].nm, "_irq"}, n);
            // scramble the live inputs once the frame has latched them
            @(posedge clk);
            #1;
            cr_gain = ~vt[i].g;
            ch_data = ~vt[i].s;
            @(negedge clk);
            chk({vt[i].nm, "_issue"}, egr_mul_valid, 1);
            chk({vt[i].nm, "_op_sample"}, egr_mul_sample, vt[i].s[AW-1:0]);
            chk({vt[i].nm, "_op_gain"}, egr_mul_gain, vt[i].g[GW-1:0]);
            wait_pulse(1, 20, {vt[i].nm, "_mix"}, n);
            chk({vt[i].nm, "_latency"}, n, 6);
            chk({vt[i].nm, "_data"}, mix_data, vt[i].exp);
            @(negedge clk);
            chk({vt[i].nm, "_pulse_end"}, mix_valid, 0);
        end

        // steady state: one irq every 10 cycles, mix 7 cycles after each irq
        cr_gain = vt[0].g;
        ch_data = vt[0].s;
        wait_pulse(0, 25, "period_irq", n);
        c_irq = 0;
        c_mix = 0;
        for (int k = 0; k < 27; k++) begin
            @(negedge clk);
            if (sampling_irq) c_irq++;
            if (mix_valid) c_mix++;
        end
        chk("period_irq_count", c_irq, 2);
        chk("period_mix_count", c_mix, 3);

        // overrun: stall the first issue across the next tick
        egr_mul_ready = 1'b0;
        wait_pulse(0, 20, "ovr_irq", n);
        repeat (4) @(negedge clk);
        chk("ovr_stall_valid", egr_mul_valid, 1);
        chk("ovr_stall_sample", egr_mul_sample, 100);
        repeat (6) @(negedge clk);
        chk("ovr_drop_irq", sampling_irq, 0);
        egr_mul_ready = 1'b1;
        wait_pulse(1, 20, "ovr_mix", n);
        chk("ovr_mix_data", mix_data, 600);
        chk("ovr_count", sr_overrun_count, 1);
        wait_pulse(0, 20, "ovr_next_irq", n);
        wait_pulse(1, 20, "ovr_next_mix", n);
        chk("ovr_next_latency", n, 7);
        chk("ovr_next_data", mix_data, 600);
        chk("ovr_count_hold", sr_overrun_count, 1);

        // reset while waiting for the first product
        wait_pulse(0, 20, "rstw_irq", n);
        @(negedge clk);
        @(negedge clk);
        chk("rstw_in_wait", egr_mul_valid, 0);
        rst = 1'b1;
        @(negedge clk);
        chk("rstw_egr_valid", egr_mul_valid, 0);
        chk("rstw_mix_valid", mix_valid, 0);
        chk("rstw_mix_data", mix_data, 0);
        chk("rstw_irq", sampling_irq, 0);
        chk("rstw_overrun", sr_overrun_count, 0);
        chk("rstw_sample", egr_mul_sample, 0);
        @(negedge clk);
        rst = 1'b0;
        k_irq = -1;
        c_mix = 0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (sampling_irq && k_irq < 0) k_irq = k;
            if (mix_valid) c_mix++;
        end
        chk("rstw_first_tick", k_irq, 9);
        chk("rstw_no_mix", c_mix, 0);
        wait_pulse(1, 20, "rstw_mix", n);
        chk("rstw_mix_after", mix_data, 600);

        // enable dropped while issuing: frame finishes, ticks stop
        wait_pulse(0, 20, "en_irq", n);
        @(negedge clk);
        chk("en_issue", egr_mul_valid, 1);
        cr_enable = 1'b0;
        wait_pulse(1, 20, "en_mix", n);
        chk("en_mix_data", mix_data, 600);
        c_irq = 0;
        for (int k = 0; k < 25; k++) begin
            @(negedge clk);
            if (sampling_irq) c_irq++;
        end
        chk("en_off_irq", c_irq, 0);
        cr_enable = 1'b1;
        wait_pulse(0, 20, "en_reon_irq", n);
        chk("en_reon_delay", n, 9);
        wait_pulse(1, 20, "en_reon_mix", n);
        chk("en_reon_data", mix_data, 600);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1);
    end

endmodule
